if_fetch: RTL and testbench

- Instruction-fetch producer for the IF/ID pipeline register. Generates the PC and runs a request/acknowledge handshake to instruction memory.
- Buffers one returned instruction and presents it on if_pc/if_inst until the pipeline consumes it.
- Raises stallreq_o to the stall controller whenever no fetched instruction is available.
- Handles delayed-branch redirects from ID and pipeline flushes.

---
 rtl/if_fetch.sv | 150 +++++++++++++++
 tb/tb_if_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: generates the PC, runs the imem req/ack handshake and
// holds one fetched instruction until the pipeline consumes it.
module if_fetch #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           DATA_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic              squash_q, squash_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    logic [ADDR_W-1:0] flush_pc;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc_next;

    // Only stall[0] concerns this stage; the other bits belong to later stages.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    // Fetch addresses are always word aligned.
    assign flush_pc  = {new_pc[ADDR_W-1:2], 2'b00};
    assign br_target = {branch_target_address_i[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            req_q         <= 1'b0;
            addr_q        <= '0;
            buf_q         <= '0;
            buf_pc_q      <= '0;
            squash_q      <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            buf_q         <= buf_d;
            buf_pc_q      <= buf_pc_d;
            squash_q      <= squash_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Next-state: flush dominates; otherwise branches are recorded and the FSM advances.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_d         = req_q;
        addr_d        = addr_q;
        buf_d         = buf_q;
        buf_pc_d      = buf_pc_q;
        squash_d      = squash_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pc_next       = ADDR_W'(buf_pc_q + ADDR_W'(4));

        if (flush) begin
            pc_d         = flush_pc;
            pend_valid_d = 1'b0;
            if (state_q == ST_REQ && !imem_ack_i) begin
                // Request cannot be withdrawn; drop its data when it returns.
                squash_d = 1'b1;
            end else begin
                squash_d = 1'b0;
                req_d    = 1'b1;
                addr_d   = flush_pc;
                state_d  = ST_REQ;
            end
        end else begin
            if (branch_flag_i) begin
                pend_valid_d  = 1'b1;
                pend_target_d = br_target;
            end
            case (state_q)
                ST_IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack_i) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            addr_d   = pc_q;
                        end else begin
                            buf_d    = imem_rdata_i;
                            buf_pc_d = addr_q;
                            req_d    = 1'b0;
                            state_d  = ST_VALID;
                        end
                    end
                end
                ST_VALID: begin
                    if (!stall[0]) begin
                        if (branch_flag_i) begin
                            pc_next = br_target;
                        end else if (pend_valid_q) begin
                            pc_next = pend_target_q;
                        end
                        pc_d         = pc_next;
                        pend_valid_d = 1'b0;
                        req_d        = 1'b1;
                        addr_d       = pc_next;
                        state_d      = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign stallreq_o  = (state_q != ST_VALID) && !rst;
    assign if_pc       = rst ? '0 : ((state_q == ST_VALID) ? buf_pc_q : pc_q);
    assign if_inst     = (rst || state_q != ST_VALID) ? '0 : buf_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch with a memory returning addr+0x100.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_o;

    logic        auto_ack;
    logic        man_ack;
    int          n_checks = 0;
    int          n_errors = 0;

    if_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .imem_req_o              (imem_req_o),
        .imem_addr_o             (imem_addr_o),
        .imem_ack_i              (imem_ack_i),
        .imem_rdata_i            (imem_rdata_i),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq_o              (stallreq_o)
    );

    always #5 clk = ~clk;

    assign imem_ack_i   = auto_ack ? imem_req_o : man_ack;
    assign imem_rdata_i = imem_addr_o + 32'h100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_valid(input string tag, input logic [31:0] pc);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_inst"}, if_inst, pc + 32'h100);
        check({tag, "_stallreq"}, 32'(stallreq_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;
        auto_ack = 1'b1; man_ack = 1'b0;

        // Reset values
        cyc(); cyc();
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        rst = 1'b0;

        // Zero-wait memory: one instruction every two cycles
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("zw_req", 32'(imem_req_o), 32'd1);
            check("zw_addr", imem_addr_o, 32'(k * 4));
            check("zw_stallreq", 32'(stallreq_o), 32'd1);
            cyc();
            check_valid("zw", 32'(k * 4));
            check("zw_req_lo", 32'(imem_req_o), 32'd0);
        end

        // Ack delayed three cycles
        auto_ack = 1'b0;
        cyc();
        check("dly_addr0", imem_addr_o, 32'h10);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("dly_addr", imem_addr_o, 32'h10);
            check("dly_req", 32'(imem_req_o), 32'd1);
            check("dly_stallreq", 32'(stallreq_o), 32'd1);
        end
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        check_valid("dly", 32'h10);

        // Branch while fetch outstanding: delay slot delivered, then target
        cyc();
        check("br_addr_slot", imem_addr_o, 32'h14);
        branch_flag_i = 1'b1; branch_target_address_i = 32'h43;
        cyc();
        branch_flag_i = 1'b0;
        check("br_addr_held", imem_addr_o, 32'h14);
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        check_valid("br_slot", 32'h14);
        cyc();
        check("br_addr_tgt", imem_addr_o, 32'h40);
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        check_valid("br_tgt", 32'h40);

        // Branch on the consume edge redirects immediately
        branch_flag_i = 1'b1; branch_target_address_i = 32'h80;
        cyc();
        branch_flag_i = 1'b0;
        check("brc_addr", imem_addr_o, 32'h80);
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        check_valid("brc", 32'h80);

        // Flush while request unacked: first ack squashed, refetch from new_pc
        cyc();
        check("fl_addr_old", imem_addr_o, 32'h84);
        flush = 1'b1; new_pc = 32'h180;
        cyc();
        flush = 1'b0;
        check("fl_addr_held", imem_addr_o, 32'h84);
        check("fl_req_held", 32'(imem_req_o), 32'd1);
        check("fl_inst", if_inst, 32'h0);
        man_ack = 1'b1;
        cyc();
        check("fl_sq_inst", if_inst, 32'h0);
        check("fl_sq_stallreq", 32'(stallreq_o), 32'd1);
        check("fl_sq_req", 32'(imem_req_o), 32'd1);
        check("fl_new_addr", imem_addr_o, 32'h180);
        cyc(); man_ack = 1'b0;
        check_valid("fl", 32'h180);

        // Flush in VALID with unaligned new_pc is forced to word alignment
        flush = 1'b1; new_pc = 32'h203;
        cyc();
        flush = 1'b0;
        check("flv_addr", imem_addr_o, 32'h200);
        check("flv_stallreq", 32'(stallreq_o), 32'd1);
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        check_valid("flv", 32'h200);

        // Stall holds the buffer and issues no request
        stall = 6'b000001;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_valid("stl", 32'h200);
            check("stl_req", 32'(imem_req_o), 32'd0);
        end
        stall = '0;
        cyc();
        check("stl_rel_addr", imem_addr_o, 32'h204);
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        check_valid("stl_rel", 32'h204);

        // PC+4 wraps at the top of the address space
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        cyc();
        flush = 1'b0;
        check("wr_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        check("wr_pc", if_pc, 32'hFFFF_FFFC);
        check("wr_inst", if_inst, 32'h0000_00FC);
        cyc();
        check("wr_addr_zero", imem_addr_o, 32'h0);
        check("wr_req", 32'(imem_req_o), 32'd1);

        // Reset mid-request, ack arriving the next cycle is ignored
        rst = 1'b1;
        cyc();
        check("mrst_req", 32'(imem_req_o), 32'd0);
        check("mrst_pc", if_pc, 32'h0);
        check("mrst_inst", if_inst, 32'h0);
        check("mrst_stallreq", 32'(stallreq_o), 32'd0);
        rst = 1'b0; man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        check("mrst_ign_stallreq", 32'(stallreq_o), 32'd1);
        check("mrst_ign_inst", if_inst, 32'h0);
        check("mrst_restart_addr", imem_addr_o, 32'h0);
        check("mrst_restart_req", 32'(imem_req_o), 32'd1);
        man_ack = 1'b1; cyc(); man_ack = 1'b0;
        check_valid("mrst", 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
